// File: rtl/apu_shared_dispatch.sv
// apu_shared_dispatch: shares NB_UNITS identical fixed-latency APUs among NB_CORES cores.
// Core requests are granted round-robin, the issuing core travels with each op in a
// per-unit tag pipe, and each unit result is routed back to the core that issued it.
module apu_shared_dispatch #(
  parameter int NB_CORES = 4,
  parameter int NB_UNITS = 2,
  parameter int WARG     = 32,
  parameter int NARGS    = 3,
  parameter int WOP      = 6,
  parameter int NDSFLAGS = 15,
  parameter int NUSFLAGS = 5,
  parameter int WRESULT  = 32,
  parameter int LATENCY  = 2
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic [NB_CORES-1:0]                     core_req_i,
  output logic [NB_CORES-1:0]                     core_gnt_o,
  input  logic [NB_CORES*NARGS*WARG-1:0]          core_operands_i,
  input  logic [NB_CORES*WOP-1:0]                 core_op_i,
  input  logic [NB_CORES*NDSFLAGS-1:0]            core_flags_i,
  output logic [NB_CORES-1:0]                     core_rvalid_o,
  output logic [NB_CORES*WRESULT-1:0]             core_result_o,
  output logic [NB_CORES*NUSFLAGS-1:0]            core_flags_o,
  output logic [NB_UNITS-1:0]                     unit_req_o,
  output logic [NB_UNITS*NARGS*WARG-1:0]          unit_operands_o,
  output logic [NB_UNITS*WOP-1:0]                 unit_op_o,
  output logic [NB_UNITS*NDSFLAGS-1:0]            unit_flags_o,
  input  logic [NB_UNITS-1:0]                     unit_rvalid_i,
  input  logic [NB_UNITS*WRESULT-1:0]             unit_result_i,
  input  logic [NB_UNITS*NUSFLAGS-1:0]            unit_flags_i,
  output logic [$clog2(NB_UNITS*LATENCY+1)-1:0]   inflight_o,
  output logic                                    tag_err_o
);

  localparam int CW  = $clog2(NB_CORES);
  localparam int IW  = $clog2(NB_UNITS*LATENCY+1);
  localparam int GW  = $clog2(LATENCY+1);
  localparam int OPW = NARGS*WARG;

  logic [CW-1:0]               rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]               unit_core_id [NB_UNITS];
  logic                        tag_vld_q [NB_UNITS][LATENCY];
  logic                        tag_vld_d [NB_UNITS][LATENCY];
  logic [CW-1:0]               tag_id_q  [NB_UNITS][LATENCY];
  logic [CW-1:0]               tag_id_d  [NB_UNITS][LATENCY];
  logic [NB_CORES-1:0]         core_rvalid_q, core_rvalid_d;
  logic [NB_CORES*WRESULT-1:0] core_result_q, core_result_d;
  logic [NB_CORES*NUSFLAGS-1:0] core_flags_q, core_flags_d;
  logic [IW-1:0]               inflight_q, inflight_d;
  logic                        tag_err_q, tag_err_d;
  logic [GW-1:0]               gate_cnt_q, gate_cnt_d;
  logic                        err_en;

  // Round-robin scan from the pointer: the k-th requester found is placed on unit k
  always_comb begin
    int idx;
    int k;
    int ptr_int;
    core_gnt_o = '0;
    unit_req_o = '0;
    rr_ptr_d   = rr_ptr_q;
    idx        = 0;
    k          = 0;
    ptr_int    = int'(rr_ptr_q);
    for (int u = 0; u < NB_UNITS; u++) begin
      unit_core_id[u] = '0;
    end
    for (int off = 0; off < NB_CORES; off++) begin
      idx = ptr_int + off;
      if (idx >= NB_CORES) begin
        idx = idx - NB_CORES;
      end
      for (int c = 0; c < NB_CORES; c++) begin
        if (c == idx && core_req_i[c] && k < NB_UNITS) begin
          core_gnt_o[c] = 1'b1;
          for (int u = 0; u < NB_UNITS; u++) begin
            if (u == k) begin
              unit_req_o[u]   = 1'b1;
              unit_core_id[u] = CW'(c);
            end
          end
          rr_ptr_d = (c == NB_CORES - 1) ? '0 : CW'(c + 1);
          k        = k + 1;
        end
      end
    end
  end

  // Steer each granted core's operands, opcode and flags onto its unit
  always_comb begin
    unit_operands_o = '0;
    unit_op_o       = '0;
    unit_flags_o    = '0;
    for (int u = 0; u < NB_UNITS; u++) begin
      for (int c = 0; c < NB_CORES; c++) begin
        if (unit_req_o[u] && unit_core_id[u] == CW'(c)) begin
          unit_operands_o[u*OPW +: OPW]           = core_operands_i[c*OPW +: OPW];
          unit_op_o[u*WOP +: WOP]                 = core_op_i[c*WOP +: WOP];
          unit_flags_o[u*NDSFLAGS +: NDSFLAGS]    = core_flags_i[c*NDSFLAGS +: NDSFLAGS];
        end
      end
    end
  end

  // Tag pipes shift the issuing core id alongside each op through the unit latency
  always_comb begin
    for (int u = 0; u < NB_UNITS; u++) begin
      tag_vld_d[u][0] = unit_req_o[u];
      tag_id_d[u][0]  = unit_core_id[u];
      for (int s = 1; s < LATENCY; s++) begin
        tag_vld_d[u][s] = tag_vld_q[u][s-1];
        tag_id_d[u][s]  = tag_id_q[u][s-1];
      end
    end
  end

  // Error checking stays off until the unit pipelines have flushed after reset
  always_comb begin
    err_en     = (gate_cnt_q == GW'(LATENCY));
    gate_cnt_d = err_en ? gate_cnt_q : gate_cnt_q + GW'(1);
  end

  // Route matched unit results to their cores and flag valid/tag disagreements
  always_comb begin
    core_rvalid_d = '0;
    core_result_d = core_result_q;
    core_flags_d  = core_flags_q;
    tag_err_d     = tag_err_q;
    for (int u = 0; u < NB_UNITS; u++) begin
      if (tag_vld_q[u][LATENCY-1] && unit_rvalid_i[u]) begin
        for (int c = 0; c < NB_CORES; c++) begin
          if (tag_id_q[u][LATENCY-1] == CW'(c)) begin
            core_rvalid_d[c]                         = 1'b1;
            core_result_d[c*WRESULT +: WRESULT]      = unit_result_i[u*WRESULT +: WRESULT];
            core_flags_d[c*NUSFLAGS +: NUSFLAGS]     = unit_flags_i[u*NUSFLAGS +: NUSFLAGS];
          end
        end
      end
      if (err_en && (unit_rvalid_i[u] != tag_vld_q[u][LATENCY-1])) begin
        tag_err_d = 1'b1;
      end
    end
  end

  // Count ops issued this cycle in and results handed to cores this cycle out
  always_comb begin
    inflight_d = inflight_q;
    for (int u = 0; u < NB_UNITS; u++) begin
      if (unit_req_o[u]) begin
        inflight_d = inflight_d + IW'(1);
      end
    end
    for (int c = 0; c < NB_CORES; c++) begin
      if (core_rvalid_d[c]) begin
        inflight_d = inflight_d - IW'(1);
      end
    end
  end

  // State registers; reset drops all in-flight tracking at once
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q      <= '0;
      core_rvalid_q <= '0;
      core_result_q <= '0;
      core_flags_q  <= '0;
      inflight_q    <= '0;
      tag_err_q     <= 1'b0;
      gate_cnt_q    <= '0;
      for (int u = 0; u < NB_UNITS; u++) begin
        for (int s = 0; s < LATENCY; s++) begin
          tag_vld_q[u][s] <= 1'b0;
          tag_id_q[u][s]  <= '0;
        end
      end
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      core_rvalid_q <= core_rvalid_d;
      core_result_q <= core_result_d;
      core_flags_q  <= core_flags_d;
      inflight_q    <= inflight_d;
      tag_err_q     <= tag_err_d;
      gate_cnt_q    <= gate_cnt_d;
      for (int u = 0; u < NB_UNITS; u++) begin
        for (int s = 0; s < LATENCY; s++) begin
          tag_vld_q[u][s] <= tag_vld_d[u][s];
          tag_id_q[u][s]  <= tag_id_d[u][s];
        end
      end
    end
  end

  assign core_rvalid_o = core_rvalid_q;
  assign core_result_o = core_result_q;
  assign core_flags_o  = core_flags_q;
  assign inflight_o    = inflight_q;
  assign tag_err_o     = tag_err_q;

endmodule

// File: tb/tb_apu_shared_dispatch.sv
// Directed bench for apu_shared_dispatch: a 4-core/2-unit/latency-2 instance and a
// 4-core/1-unit/latency-1 instance, each fed by a simple echo unit model that returns
// operand 0 as the result and opcode[4:0] as the flags after the unit latency.
module tb_apu_shared_dispatch;

  localparam int NC  = 4;
  localparam int NU  = 2;
  localparam int WA  = 32;
  localparam int NA  = 3;
  localparam int WO  = 6;
  localparam int ND  = 15;
  localparam int NF  = 5;
  localparam int WR  = 32;
  localparam int LAT = 2;
  localparam int OPW = NA*WA;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;

  always #5 clk_i = ~clk_i;

  // shared core-side inputs
  logic [NC*OPW-1:0] core_operands_i;
  logic [NC*WO-1:0]  core_op_i;
  logic [NC*ND-1:0]  core_flags_i;

  // instance A (2 units, latency 2)
  logic [NC-1:0]    core_req_i;
  logic [NC-1:0]    core_gnt_o;
  logic [NC-1:0]    core_rvalid_o;
  logic [NC*WR-1:0] core_result_o;
  logic [NC*NF-1:0] core_flags_o;
  logic [NU-1:0]    unit_req_o;
  logic [NU*OPW-1:0] unit_operands_o;
  logic [NU*WO-1:0] unit_op_o;
  logic [NU*ND-1:0] unit_flags_o;
  logic [NU-1:0]    unit_rvalid_i;
  logic [NU*WR-1:0] unit_result_i;
  logic [NU*NF-1:0] unit_flags_i;
  logic [2:0]       inflight_o;
  logic             tag_err_o;
  logic [NU-1:0]    inject;

  // instance B (1 unit, latency 1)
  logic [NC-1:0]    core_req_b;
  logic [NC-1:0]    core_gnt_b;
  logic [NC-1:0]    core_rvalid_b;
  logic [NC*WR-1:0] core_result_b;
  logic [NC*NF-1:0] core_flags_b;
  logic [0:0]       unit_req_b;
  logic [OPW-1:0]   unit_operands_b;
  logic [WO-1:0]    unit_op_b;
  logic [ND-1:0]    unit_flags_b;
  logic [0:0]       unit_rvalid_b;
  logic [WR-1:0]    unit_result_b;
  logic [NF-1:0]    unit_uflags_b;
  logic [0:0]       inflight_b;
  logic             tag_err_b;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [31:0] arg0Tab [NC] = '{32'h1111_0000, 32'hDEAD_BEEF, 32'h2222_0000, 32'h3333_0000};

  apu_shared_dispatch #(
    .NB_CORES(NC), .NB_UNITS(NU), .WARG(WA), .NARGS(NA), .WOP(WO),
    .NDSFLAGS(ND), .NUSFLAGS(NF), .WRESULT(WR), .LATENCY(LAT)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .core_req_i(core_req_i), .core_gnt_o(core_gnt_o),
    .core_operands_i(core_operands_i), .core_op_i(core_op_i), .core_flags_i(core_flags_i),
    .core_rvalid_o(core_rvalid_o), .core_result_o(core_result_o), .core_flags_o(core_flags_o),
    .unit_req_o(unit_req_o), .unit_operands_o(unit_operands_o), .unit_op_o(unit_op_o),
    .unit_flags_o(unit_flags_o), .unit_rvalid_i(unit_rvalid_i), .unit_result_i(unit_result_i),
    .unit_flags_i(unit_flags_i), .inflight_o(inflight_o), .tag_err_o(tag_err_o)
  );

  apu_shared_dispatch #(
    .NB_CORES(NC), .NB_UNITS(1), .WARG(WA), .NARGS(NA), .WOP(WO),
    .NDSFLAGS(ND), .NUSFLAGS(NF), .WRESULT(WR), .LATENCY(1)
  ) dutB (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .core_req_i(core_req_b), .core_gnt_o(core_gnt_b),
    .core_operands_i(core_operands_i), .core_op_i(core_op_i), .core_flags_i(core_flags_i),
    .core_rvalid_o(core_rvalid_b), .core_result_o(core_result_b), .core_flags_o(core_flags_b),
    .unit_req_o(unit_req_b), .unit_operands_o(unit_operands_b), .unit_op_o(unit_op_b),
    .unit_flags_o(unit_flags_b), .unit_rvalid_i(unit_rvalid_b), .unit_result_i(unit_result_b),
    .unit_flags_i(unit_uflags_b), .inflight_o(inflight_b), .tag_err_o(tag_err_b)
  );

  // unit models are not reset: results of ops cut off by reset still come back
  logic [NU-1:0]    uaV1 = '0, uaV2 = '0;
  logic [NU*WR-1:0] uaR1 = '0, uaR2 = '0, uaResNow;
  logic [NU*NF-1:0] uaF1 = '0, uaF2 = '0, uaFlgNow;
  logic             ubV1 = 1'b0;
  logic [WR-1:0]    ubR1 = '0;
  logic [NF-1:0]    ubF1 = '0;

  always_comb begin
    for (int u = 0; u < NU; u++) begin
      uaResNow[u*WR +: WR] = unit_operands_o[u*OPW +: WR];
      uaFlgNow[u*NF +: NF] = unit_op_o[u*WO +: NF];
    end
  end

  always @(posedge clk_i) begin
    uaV1 <= unit_req_o;
    uaR1 <= uaResNow;
    uaF1 <= uaFlgNow;
    uaV2 <= uaV1;
    uaR2 <= uaR1;
    uaF2 <= uaF1;
    ubV1 <= unit_req_b[0];
    ubR1 <= unit_operands_b[WR-1:0];
    ubF1 <= unit_op_b[NF-1:0];
  end

  assign unit_rvalid_i    = uaV2 | inject;
  assign unit_result_i    = uaR2;
  assign unit_flags_i     = uaF2;
  assign unit_rvalid_b[0] = ubV1;
  assign unit_result_b    = ubR1;
  assign unit_uflags_b    = ubF1;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [NC-1:0] reqA, input logic [NC-1:0] reqB);
    @(posedge clk_i);
    #1;
    core_req_i = reqA;
    core_req_b = reqB;
    #1;
  endtask

  logic [3:0] t2Gnt [8] = '{4'b0011, 4'b1100, 4'b0011, 4'b1100, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
  logic [3:0] t2Rv  [8] = '{4'b0000, 4'b0000, 4'b0000, 4'b0011, 4'b1100, 4'b0011, 4'b1100, 4'b0000};
  logic [2:0] t2Inf [8] = '{3'd0, 3'd2, 3'd4, 3'd4, 3'd4, 3'd2, 3'd0, 3'd0};
  logic [3:0] t6Rv  [7] = '{4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000};
  logic       t6Inf [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    int rvCount [NC];
    core_req_i = '0;
    core_req_b = '0;
    inject     = '0;
    for (int c = 0; c < NC; c++) begin
      core_operands_i[c*OPW +: OPW] = {32'hCAFE_0000 + 32'(c), 32'h0101_0101 * 32'(c), arg0Tab[c]};
      core_op_i[c*WO +: WO]         = 6'(2*c + 1);
      core_flags_i[c*ND +: ND]      = 15'(16'h0100 + 16'(c));
      rvCount[c]                    = 0;
    end

    // reset state
    #3;
    checkOutput("rst_rvalid", 64'(core_rvalid_o), 64'h0);
    checkOutput("rst_result", 64'(core_result_o[63:0]), 64'h0);
    checkOutput("rst_flags", 64'(core_flags_o), 64'h0);
    checkOutput("rst_inflight", 64'(inflight_o), 64'h0);
    checkOutput("rst_tagerr", 64'(tag_err_o), 64'h0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    repeat (4) applyStimulus('0, '0);

    // single request from core 1
    applyStimulus(4'b0010, '0);
    checkOutput("t1_gnt", 64'(core_gnt_o), 64'h2);
    checkOutput("t1_ureq", 64'(unit_req_o), 64'h1);
    checkOutput("t1_uop", 64'(unit_op_o[5:0]), 64'h3);
    checkOutput("t1_uarg", 64'(unit_operands_o[31:0]), 64'hDEADBEEF);
    applyStimulus('0, '0);
    checkOutput("t1_infl1", 64'(inflight_o), 64'h1);
    checkOutput("t1_rv1", 64'(core_rvalid_o), 64'h0);
    applyStimulus('0, '0);
    checkOutput("t1_rv2", 64'(core_rvalid_o), 64'h0);
    applyStimulus('0, '0);
    checkOutput("t1_rv3", 64'(core_rvalid_o), 64'h2);
    checkOutput("t1_res", 64'(core_result_o[63:32]), 64'hDEADBEEF);
    checkOutput("t1_flg", 64'(core_flags_o[9:5]), 64'h3);
    checkOutput("t1_infl3", 64'(inflight_o), 64'h0);

    // wrap-around arbitration from pointer 2
    applyStimulus(4'b1001, '0);
    checkOutput("t3_gnt", 64'(core_gnt_o), 64'h9);
    checkOutput("t3_ureq", 64'(unit_req_o), 64'h3);
    checkOutput("t3_u0arg", 64'(unit_operands_o[31:0]), 64'h33330000);
    checkOutput("t3_u1arg", 64'(unit_operands_o[OPW +: 32]), 64'h11110000);
    applyStimulus(4'b0011, '0);
    checkOutput("t3_ptr_gnt", 64'(core_gnt_o), 64'h3);
    checkOutput("t3_ptr_u0arg", 64'(unit_operands_o[31:0]), 64'hDEADBEEF);
    checkOutput("t3_ptr_u1arg", 64'(unit_operands_o[OPW +: 32]), 64'h11110000);
    applyStimulus(4'b1000, '0);
    checkOutput("t3_c3_gnt", 64'(core_gnt_o), 64'h8);
    checkOutput("t3_c3_ureq", 64'(unit_req_o), 64'h1);
    applyStimulus('0, '0);
    checkOutput("t3_rv_a", 64'(core_rvalid_o), 64'h9);
    checkOutput("t3_res3", 64'(core_result_o[127:96]), 64'h33330000);
    checkOutput("t3_res0", 64'(core_result_o[31:0]), 64'h11110000);
    checkOutput("t3_flg3", 64'(core_flags_o[19:15]), 64'h7);
    checkOutput("t3_infl", 64'(inflight_o), 64'h3);
    applyStimulus('0, '0);
    checkOutput("t3_rv_b", 64'(core_rvalid_o), 64'h3);
    checkOutput("t3_res1", 64'(core_result_o[63:32]), 64'hDEADBEEF);
    applyStimulus('0, '0);
    checkOutput("t3_rv_c", 64'(core_rvalid_o), 64'h8);
    checkOutput("t3_infl_end", 64'(inflight_o), 64'h0);

    // all four cores request for four cycles starting at pointer 0
    for (int cyc = 0; cyc < 8; cyc++) begin
      applyStimulus((cyc < 4) ? 4'b1111 : 4'b0000, '0);
      checkOutput($sformatf("t2_gnt_%0d", cyc), 64'(core_gnt_o), 64'(t2Gnt[cyc]));
      checkOutput($sformatf("t2_rv_%0d", cyc), 64'(core_rvalid_o), 64'(t2Rv[cyc]));
      checkOutput($sformatf("t2_infl_%0d", cyc), 64'(inflight_o), 64'(t2Inf[cyc]));
      for (int c = 0; c < NC; c++) begin
        if (core_rvalid_o[c]) rvCount[c]++;
      end
      if (cyc == 3) checkOutput("t2_res0", 64'(core_result_o[31:0]), 64'h11110000);
      if (cyc == 4) checkOutput("t2_res3", 64'(core_result_o[127:96]), 64'h33330000);
    end
    for (int c = 0; c < NC; c++) begin
      checkOutput($sformatf("t2_count_%0d", c), 64'(rvCount[c]), 64'd2);
    end

    // spurious result on unit 1
    applyStimulus('0, '0);
    checkOutput("t4_err_before", 64'(tag_err_o), 64'h0);
    inject = 2'b10;
    applyStimulus('0, '0);
    inject = 2'b00;
    checkOutput("t4_err", 64'(tag_err_o), 64'h1);
    checkOutput("t4_rv", 64'(core_rvalid_o), 64'h0);
    applyStimulus('0, '0);
    checkOutput("t4_err_sticky", 64'(tag_err_o), 64'h1);
    checkOutput("t4_rv2", 64'(core_rvalid_o), 64'h0);
    checkOutput("t4_infl", 64'(inflight_o), 64'h0);

    // reset one cycle after a dual issue
    applyStimulus(4'b0011, '0);
    checkOutput("t5_ureq", 64'(unit_req_o), 64'h3);
    applyStimulus('0, '0);
    checkOutput("t5_infl_pre", 64'(inflight_o), 64'h2);
    rst_ni = 1'b0;
    #1;
    checkOutput("t5_rst_rv", 64'(core_rvalid_o), 64'h0);
    checkOutput("t5_rst_infl", 64'(inflight_o), 64'h0);
    checkOutput("t5_rst_err", 64'(tag_err_o), 64'h0);
    checkOutput("t5_rst_res", 64'(core_result_o[63:0]), 64'h0);
    applyStimulus('0, '0);
    rst_ni = 1'b1;
    applyStimulus('0, '0);
    checkOutput("t5_post_rv", 64'(core_rvalid_o), 64'h0);
    checkOutput("t5_post_err", 64'(tag_err_o), 64'h0);
    applyStimulus('0, '0);
    checkOutput("t5_post_rv2", 64'(core_rvalid_o), 64'h0);
    checkOutput("t5_post_err2", 64'(tag_err_o), 64'h0);
    checkOutput("t5_post_infl", 64'(inflight_o), 64'h0);
    repeat (3) applyStimulus('0, '0);

    // single unit, latency 1: back-to-back requests from core 2
    for (int cyc = 0; cyc < 7; cyc++) begin
      applyStimulus('0, (cyc < 4) ? 4'b0100 : 4'b0000);
      checkOutput($sformatf("t6_gnt_%0d", cyc), 64'(core_gnt_b), (cyc < 4) ? 64'h4 : 64'h0);
      checkOutput($sformatf("t6_rv_%0d", cyc), 64'(core_rvalid_b), 64'(t6Rv[cyc]));
      checkOutput($sformatf("t6_infl_%0d", cyc), 64'(inflight_b), 64'(t6Inf[cyc]));
      if (cyc == 2) checkOutput("t6_res", 64'(core_result_b[95:64]), 64'h22220000);
    end
    checkOutput("t6_err", 64'(tag_err_b), 64'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
